// File: rtl/medidor_pkg.sv
// medidor_pkg
// Shared types and constants for the square-wave period meter.
//   estado_t     : measurement FSM state (ESPERA = idle, MIDIENDO = counting)
//   MODO_PERIODO : measure rising edge to rising edge
//   MODO_ALTO    : measure rising edge to falling edge (high time)
package medidor_pkg;

    typedef enum logic {
        ESPERA   = 1'b0,
        MIDIENDO = 1'b1
    } estado_t;

    localparam logic MODO_PERIODO = 1'b0;
    localparam logic MODO_ALTO    = 1'b1;

endpackage : medidor_pkg

// File: rtl/medidor_periodo_param_detector_flancos.sv
// detector_flancos
// Brings an asynchronous input into the clock domain with a two-flop
// synchroniser, keeps one history flop and reports single-cycle edge strobes.
// An input change first sampled at clock edge k shows up on sube/baja
// during the cycle that follows edge k+1.
// Ports:
//   reloj  in  1  clock, rising edge
//   reset  in  1  synchronous, active-high; clears all three flops
//   senal  in  1  asynchronous input
//   sube   out 1  rising-edge strobe (combinational from the flops)
//   baja   out 1  falling-edge strobe (combinational from the flops)
module detector_flancos (
    input  logic reloj,
    input  logic reset,
    input  logic senal,
    output logic sube,
    output logic baja
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge reloj) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= senal;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sube = sync2 & ~prev;
    assign baja = ~sync2 & prev;

endmodule : detector_flancos

// File: rtl/medidor_periodo_param.sv
// medidor_periodo_param
// Measures an asynchronous square wave in prescaled ticks, either the full
// period (rise to rise) or the high time (rise to fall).
// Handshake: valido is a one-cycle strobe, asserted exactly in the cycle in
// which valor_periodo first shows a new result; there is no back-pressure,
// the consumer must capture valor_periodo on that strobe or use the held value.
// Ports:
//   reloj_placa   in  1      board clock, rising edge
//   reset         in  1      synchronous, active-high
//   onda_entrada  in  1      asynchronous square wave
//   modo          in  1      MODO_PERIODO / MODO_ALTO, latched at each start
//   valor_periodo out ANCHO  last completed measurement in ticks
//   valido        out 1      one-cycle pulse when valor_periodo updates
//   desborde      out 1      sticky: no closing edge within 2^ANCHO ticks
//   midiendo      out 1      FSM state is MIDIENDO (also serves as state debug)
module medidor_periodo_param
    import medidor_pkg::*;
#(
    parameter int ANCHO         = 16,
    parameter int DIV_PRESCALER = 50,
    parameter int ANCHO_PRE     = 6
) (
    input  logic             reloj_placa,
    input  logic             reset,
    input  logic             onda_entrada,
    input  logic             modo,
    output logic [ANCHO-1:0] valor_periodo,
    output logic             valido,
    output logic             desborde,
    output logic             midiendo
);

    logic                 sube;
    logic                 baja;
    estado_t              estado;
    estado_t              estado_sig;
    logic                 modo_r;
    logic [ANCHO_PRE-1:0] pre_cnt;
    logic [ANCHO-1:0]     cnt;
    logic                 tick;
    logic                 fin;
    logic                 inicio;
    logic                 ovf;

    detector_flancos u_detector (
        .reloj (reloj_placa),
        .reset (reset),
        .senal (onda_entrada),
        .sube  (sube),
        .baja  (baja)
    );

    assign tick     = (pre_cnt == ANCHO_PRE'(DIV_PRESCALER - 1));
    assign midiendo = (estado == MIDIENDO);

    // State register
    always_ff @(posedge reloj_placa) begin
        if (reset) begin
            estado <= ESPERA;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next state and control strobes. fin has priority over overflow.
    always_comb begin
        estado_sig = estado;
        inicio     = 1'b0;
        fin        = 1'b0;
        ovf        = 1'b0;
        case (estado)
            ESPERA: begin
                if (sube) begin
                    inicio     = 1'b1;
                    estado_sig = MIDIENDO;
                end
            end
            MIDIENDO: begin
                fin = (modo_r == MODO_PERIODO) ? sube : baja;
                if (fin) begin
                    // In period mode the closing rise is also the next opening rise.
                    if (modo_r == MODO_PERIODO) begin
                        inicio = 1'b1;
                    end else begin
                        estado_sig = ESPERA;
                    end
                end else if (tick && (cnt == '1)) begin
                    ovf        = 1'b1;
                    estado_sig = ESPERA;
                end
            end
            default: begin
                estado_sig = ESPERA;
            end
        endcase
    end

    // Datapath: prescaler, tick counter, result and flags
    always_ff @(posedge reloj_placa) begin
        if (reset) begin
            pre_cnt       <= '0;
            cnt           <= '0;
            modo_r        <= MODO_PERIODO;
            valor_periodo <= '0;
            valido        <= 1'b0;
            desborde      <= 1'b0;
        end else begin
            valido <= fin;

            if (inicio || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + ANCHO_PRE'(1);
            end

            if (fin) begin
                // A tick landing on the closing cycle still belongs to this result.
                valor_periodo <= cnt + ANCHO'(tick);
                desborde      <= 1'b0;
            end else if (ovf) begin
                desborde <= 1'b1;
            end

            if (inicio) begin
                cnt    <= '0;
                modo_r <= modo;
            end else if (tick && !ovf) begin
                cnt <= cnt + ANCHO'(1);
            end
        end
    end

endmodule : medidor_periodo_param
